// File: rtl/btb_assoc_pkg.sv
// Shared frontend types for the branch target buffer.
//   VLEN             virtual address width
//   INSTR_PER_FETCH  instruction slots per fetch block
//   btb_update_t     {valid, pc, target_address} from the branch unit
//   btb_prediction_t {valid, target_address} per fetch slot
package btb_assoc_pkg;

  localparam int unsigned VLEN            = 32;
  localparam int unsigned INSTR_PER_FETCH = 2;

  typedef struct packed {
    logic            valid;
    logic [VLEN-1:0] pc;
    logic [VLEN-1:0] target_address;
  } btb_update_t;

  typedef struct packed {
    logic            valid;
    logic [VLEN-1:0] target_address;
  } btb_prediction_t;

endpackage

// File: rtl/btb_assoc_way_select.sv
// Victim selection for one (set, slot).
//   valid_i   per-way valid bits (pre-edge state)
//   rr_i      current round-robin pointer
//   victim_o  lowest-index invalid way, else the rr way
//   rr_next_o rr_i if an invalid way exists, else rr_i+1 (wraps, NR_WAYS pow2)
module btb_way_select #(
  parameter  int unsigned NR_WAYS = 2,
  localparam int unsigned RR_W    = (NR_WAYS > 1) ? $clog2(NR_WAYS) : 1
) (
  input  logic [NR_WAYS-1:0] valid_i,
  input  logic [RR_W-1:0]    rr_i,
  output logic [RR_W-1:0]    victim_o,
  output logic [RR_W-1:0]    rr_next_o
);

  logic found;

  always_comb begin
    victim_o = rr_i;
    found    = 1'b0;
    for (int unsigned w = 0; w < NR_WAYS; w++) begin
      if (!valid_i[w] && !found) begin
        victim_o = RR_W'(w);
        found    = 1'b1;
      end
    end
    if (found)             rr_next_o = rr_i;
    else if (NR_WAYS > 1)  rr_next_o = RR_W'(rr_i + 1'b1);
    else                   rr_next_o = '0;
  end

endmodule

// File: rtl/btb_assoc.sv
// Tagged N-way set-associative branch target buffer.
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   clr_i              synchronous clear of all state
//   flush_i            invalidate all entries, reset rr pointers
//   debug_mode_i       blocks updates/invalidates, lookups still served
//   vpc_i              fetch PC, combinational lookup
//   btb_update_i       install/overwrite a target from the branch unit
//   inv_valid_i/inv_pc_i  invalidate the entry matching inv_pc_i
//   btb_prediction_o   per-slot {valid, target}
module btb_assoc
  import btb_assoc_pkg::*;
#(
  parameter int unsigned NR_ENTRIES = 32,
  parameter int unsigned NR_WAYS    = 2,
  parameter int unsigned TAG_BITS   = 8
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   clr_i,
  input  logic                                   flush_i,
  input  logic                                   debug_mode_i,
  input  logic [VLEN-1:0]                        vpc_i,
  input  btb_update_t                            btb_update_i,
  input  logic                                   inv_valid_i,
  input  logic [VLEN-1:0]                        inv_pc_i,
  output btb_prediction_t [INSTR_PER_FETCH-1:0]  btb_prediction_o
);

  localparam int unsigned IPF             = INSTR_PER_FETCH;
  localparam int unsigned OFFSET          = 1;
  localparam int unsigned ROW_BITS        = $clog2(IPF);
  localparam int unsigned NR_SETS         = NR_ENTRIES / (IPF * NR_WAYS);
  localparam int unsigned SET_BITS        = $clog2(NR_SETS);
  localparam int unsigned PREDICTION_BITS = SET_BITS + ROW_BITS + OFFSET;
  localparam int unsigned SET_W           = (SET_BITS > 0) ? SET_BITS : 1;
  localparam int unsigned SLOT_W          = (ROW_BITS > 0) ? ROW_BITS : 1;
  localparam int unsigned RR_W            = (NR_WAYS > 1) ? $clog2(NR_WAYS) : 1;

  if (NR_ENTRIES == 0 || (NR_ENTRIES & (NR_ENTRIES - 1)) != 0) begin : g_chk_entries
    $error("NR_ENTRIES must be a power of two");
  end
  if (NR_WAYS == 0 || (NR_WAYS & (NR_WAYS - 1)) != 0) begin : g_chk_ways
    $error("NR_WAYS must be a power of two");
  end
  if (NR_ENTRIES < IPF * NR_WAYS) begin : g_chk_size
    $error("NR_ENTRIES must be >= INSTR_PER_FETCH*NR_WAYS");
  end
  if (TAG_BITS < 1 || PREDICTION_BITS + TAG_BITS > VLEN) begin : g_chk_tag
    $error("TAG_BITS out of range");
  end

  typedef struct packed {
    logic                valid;
    logic [TAG_BITS-1:0] tag;
    logic [VLEN-1:0]     target;
  } entry_t;

  function automatic logic [SET_W-1:0] set_of(input logic [VLEN-1:0] pc);
    return SET_W'(pc >> (ROW_BITS + OFFSET)) & SET_W'(NR_SETS - 1);
  endfunction

  function automatic logic [SLOT_W-1:0] slot_of(input logic [VLEN-1:0] pc);
    return SLOT_W'(pc >> OFFSET) & SLOT_W'(IPF - 1);
  endfunction

  function automatic logic [TAG_BITS-1:0] tag_of(input logic [VLEN-1:0] pc);
    return pc[PREDICTION_BITS +: TAG_BITS];
  endfunction

  entry_t          entry_q [NR_SETS][IPF][NR_WAYS];
  entry_t          entry_d [NR_SETS][IPF][NR_WAYS];
  logic [RR_W-1:0] rr_q    [NR_SETS][IPF];
  logic [RR_W-1:0] rr_d    [NR_SETS][IPF];

  logic [SET_W-1:0]    upd_set, inv_set, lk_set;
  logic [SLOT_W-1:0]   upd_slot, inv_slot;
  logic [TAG_BITS-1:0] upd_tag, inv_tag, lk_tag;

  assign upd_set  = set_of(btb_update_i.pc);
  assign upd_slot = slot_of(btb_update_i.pc);
  assign upd_tag  = tag_of(btb_update_i.pc);
  assign inv_set  = set_of(inv_pc_i);
  assign inv_slot = slot_of(inv_pc_i);
  assign inv_tag  = tag_of(inv_pc_i);
  assign lk_set   = set_of(vpc_i);
  assign lk_tag   = tag_of(vpc_i);

  logic [RR_W-1:0] victim  [IPF];
  logic [RR_W-1:0] rr_nxt  [IPF];

  // One selector per slot, all looking at the set addressed by the update.
  for (genvar g = 0; g < IPF; g++) begin : g_slot
    logic [NR_WAYS-1:0] valid_vec;
    always_comb begin
      valid_vec = '0;
      for (int unsigned w = 0; w < NR_WAYS; w++) begin
        valid_vec[w] = entry_q[upd_set][g][w].valid;
      end
    end
    btb_way_select #(.NR_WAYS(NR_WAYS)) i_way_select (
      .valid_i   (valid_vec),
      .rr_i      (rr_q[upd_set][g]),
      .victim_o  (victim[g]),
      .rr_next_o (rr_nxt[g])
    );
  end

  logic            upd_en, inv_en, same_entry, do_write;
  logic            upd_hit, inv_hit;
  logic [RR_W-1:0] upd_hit_way, inv_way, write_way;

  always_comb begin
    upd_en      = btb_update_i.valid && !debug_mode_i;
    inv_en      = inv_valid_i && !debug_mode_i;
    upd_hit     = 1'b0;
    upd_hit_way = '0;
    inv_hit     = 1'b0;
    inv_way     = '0;
    for (int unsigned w = 0; w < NR_WAYS; w++) begin
      if (!upd_hit && entry_q[upd_set][upd_slot][w].valid &&
          entry_q[upd_set][upd_slot][w].tag == upd_tag) begin
        upd_hit     = 1'b1;
        upd_hit_way = RR_W'(w);
      end
      if (!inv_hit && entry_q[inv_set][inv_slot][w].valid &&
          entry_q[inv_set][inv_slot][w].tag == inv_tag) begin
        inv_hit = 1'b1;
        inv_way = RR_W'(w);
      end
    end
    // Invalidate beats an update aimed at the same entry: the update is
    // dropped entirely so it neither allocates nor advances rr.
    same_entry = upd_en && inv_en && upd_set == inv_set &&
                 upd_slot == inv_slot && upd_tag == inv_tag;
    do_write   = upd_en && !same_entry;
    write_way  = upd_hit ? upd_hit_way : victim[upd_slot];

    entry_d = entry_q;
    rr_d    = rr_q;
    if (clr_i) begin
      for (int unsigned s = 0; s < NR_SETS; s++) begin
        for (int unsigned i = 0; i < IPF; i++) begin
          rr_d[s][i] = '0;
          for (int unsigned w = 0; w < NR_WAYS; w++) entry_d[s][i][w] = '0;
        end
      end
    end else if (flush_i) begin
      for (int unsigned s = 0; s < NR_SETS; s++) begin
        for (int unsigned i = 0; i < IPF; i++) begin
          rr_d[s][i] = '0;
          for (int unsigned w = 0; w < NR_WAYS; w++) entry_d[s][i][w].valid = 1'b0;
        end
      end
    end else begin
      if (do_write) begin
        entry_d[upd_set][upd_slot][write_way].valid  = 1'b1;
        entry_d[upd_set][upd_slot][write_way].tag    = upd_tag;
        entry_d[upd_set][upd_slot][write_way].target = btb_update_i.target_address;
        if (!upd_hit) rr_d[upd_set][upd_slot] = rr_nxt[upd_slot];
      end
      // A way being overwritten by the update already loses its old entry;
      // clearing valid there would also discard the freshly written one.
      if (inv_en && inv_hit &&
          !(do_write && upd_set == inv_set && upd_slot == inv_slot && write_way == inv_way)) begin
        entry_d[inv_set][inv_slot][inv_way].valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned s = 0; s < NR_SETS; s++) begin
        for (int unsigned i = 0; i < IPF; i++) begin
          rr_q[s][i] <= '0;
          for (int unsigned w = 0; w < NR_WAYS; w++) entry_q[s][i][w] <= '0;
        end
      end
    end else begin
      entry_q <= entry_d;
      rr_q    <= rr_d;
    end
  end

  always_comb begin
    btb_prediction_o = '0;
    for (int unsigned i = 0; i < IPF; i++) begin
      for (int unsigned w = 0; w < NR_WAYS; w++) begin
        if (entry_q[lk_set][i][w].valid && entry_q[lk_set][i][w].tag == lk_tag) begin
          btb_prediction_o[i].valid          = 1'b1;
          btb_prediction_o[i].target_address = btb_prediction_o[i].target_address |
                                               entry_q[lk_set][i][w].target;
        end
      end
    end
  end

endmodule

// File: tb/tb_btb_assoc.sv
module tb_btb_assoc;
  import btb_assoc_pkg::*;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic                                  rst_ni, clr_i, flush_i, debug_mode_i, inv_valid_i;
  logic [VLEN-1:0]                       vpc_i, inv_pc_i;
  btb_update_t                           btb_update_i;
  btb_prediction_t [INSTR_PER_FETCH-1:0] btb_prediction_o;

  int checks   = 0;
  int failures = 0;

  btb_assoc #(.NR_ENTRIES(32), .NR_WAYS(2), .TAG_BITS(8)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .clr_i            (clr_i),
    .flush_i          (flush_i),
    .debug_mode_i     (debug_mode_i),
    .vpc_i            (vpc_i),
    .btb_update_i     (btb_update_i),
    .inv_valid_i      (inv_valid_i),
    .inv_pc_i         (inv_pc_i),
    .btb_prediction_o (btb_prediction_o)
  );

  btb_prediction_t p0, p1;
  localparam btb_prediction_t MISS = '0;

  task automatic look(input logic [31:0] pc);
    vpc_i = pc;
    #1;
    p0 = btb_prediction_o[0];
    p1 = btb_prediction_o[1];
  endtask

  // Inputs change at the falling edge; one rising edge captures them.
  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt);
    @(negedge clk_i);
    btb_update_i = '{valid: 1'b1, pc: pc, target_address: tgt};
    @(negedge clk_i);
    btb_update_i.valid = 1'b0;
  endtask

  task automatic inv(input logic [31:0] pc);
    @(negedge clk_i);
    inv_valid_i = 1'b1;
    inv_pc_i    = pc;
    @(negedge clk_i);
    inv_valid_i = 1'b0;
  endtask

  task automatic clear();
    @(negedge clk_i);
    clr_i = 1'b1;
    @(negedge clk_i);
    clr_i = 1'b0;
  endtask

  task automatic test_reset();
    int bad;
    logic [31:0] bad_pc;
    rst_ni = 1'b0;
    #12;
    bad = 0;
    bad_pc = '0;
    for (int a = 0; a <= 32'h2000; a += 2) begin
      look(a);
      if (p0 !== MISS || p1 !== MISS) begin
        if (bad == 0) bad_pc = a;
        bad++;
      end
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL reset_sweep: %0d hits (first pc %h) expected 0", bad, bad_pc);
    end
    @(posedge clk_i); #1 rst_ni = 1'b1;
    // Reset asserted while an update is presented at the clock edge.
    @(negedge clk_i);
    btb_update_i = '{valid: 1'b1, pc: 32'h80000010, target_address: 32'h80000100};
    #3 rst_ni = 1'b0;
    @(posedge clk_i); #1 rst_ni = 1'b1;
    @(negedge clk_i);
    btb_update_i.valid = 1'b0;
    look(32'h80000010);
    checks++;
    if (p0 !== MISS) begin
      failures++; $display("FAIL reset_mid_update: got %h expected %h", p0, MISS);
    end
    // Asynchronous reset clears a resident entry without a clock edge.
    upd(32'h80000010, 32'h80000100);
    look(32'h80000010);
    checks++;
    if (p0 !== {1'b1, 32'h80000100}) begin
      failures++; $display("FAIL reset_pre_hit: got %h expected %h", p0, {1'b1, 32'h80000100});
    end
    rst_ni = 1'b0;
    look(32'h80000010);
    checks++;
    if (p0 !== MISS || p1 !== MISS) begin
      failures++; $display("FAIL reset_async: got %h/%h expected 0", p0, p1);
    end
    @(posedge clk_i); #1 rst_ni = 1'b1;
  endtask

  task automatic test_basic();
    upd(32'h80000010, 32'h80000100);
    look(32'h80000010);
    checks++;
    if (p0 !== {1'b1, 32'h80000100}) begin
      failures++; $display("FAIL basic_hit: got %h expected %h", p0, {1'b1, 32'h80000100});
    end
    look(32'h80000030);
    checks++;
    if (p0 !== MISS) begin
      failures++; $display("FAIL basic_tag_miss: got %h expected %h", p0, MISS);
    end
    look(32'h80000012);
    checks++;
    if (p1.valid !== 1'b0) begin
      failures++; $display("FAIL basic_slot1_miss: got %b expected 0", p1.valid);
    end
    upd(32'h80000012, 32'h80000300);
    look(32'h80000010);
    checks++;
    if (p1 !== {1'b1, 32'h80000300} || p0 !== {1'b1, 32'h80000100}) begin
      failures++; $display("FAIL basic_slot1_hit: got %h/%h expected %h/%h",
                           p0, p1, {1'b1, 32'h80000100}, {1'b1, 32'h80000300});
    end
  endtask

  task automatic test_replace();
    clear();
    look(32'h80000010);
    checks++;
    if (p0 !== MISS || p1 !== MISS) begin
      failures++; $display("FAIL clr_all: got %h/%h expected 0", p0, p1);
    end
    upd(32'h80000010, 32'h80000110);
    upd(32'h80000030, 32'h80000130);
    look(32'h80000010);
    checks++;
    if (p0 !== {1'b1, 32'h80000110}) begin
      failures++; $display("FAIL fill_way0: got %h expected %h", p0, {1'b1, 32'h80000110});
    end
    look(32'h80000030);
    checks++;
    if (p0 !== {1'b1, 32'h80000130}) begin
      failures++; $display("FAIL fill_way1: got %h expected %h", p0, {1'b1, 32'h80000130});
    end
    upd(32'h80000050, 32'h80000150);
    look(32'h80000010);
    checks++;
    if (p0.valid !== 1'b0) begin
      failures++; $display("FAIL evict_way0: got valid %b expected 0", p0.valid);
    end
    look(32'h80000030);
    checks++;
    if (p0 !== {1'b1, 32'h80000130}) begin
      failures++; $display("FAIL keep_way1: got %h expected %h", p0, {1'b1, 32'h80000130});
    end
    upd(32'h80000070, 32'h80000170);
    look(32'h80000030);
    checks++;
    if (p0.valid !== 1'b0) begin
      failures++; $display("FAIL evict_way1: got valid %b expected 0", p0.valid);
    end
    look(32'h80000050);
    checks++;
    if (p0 !== {1'b1, 32'h80000150}) begin
      failures++; $display("FAIL hit_050: got %h expected %h", p0, {1'b1, 32'h80000150});
    end
    look(32'h80000070);
    checks++;
    if (p0 !== {1'b1, 32'h80000170}) begin
      failures++; $display("FAIL hit_070: got %h expected %h", p0, {1'b1, 32'h80000170});
    end
    // rr wrapped to way 0, so the next allocation evicts 0x050.
    upd(32'h80000090, 32'h80000190);
    look(32'h80000050);
    checks++;
    if (p0.valid !== 1'b0) begin
      failures++; $display("FAIL rr_wrap_evict: got valid %b expected 0", p0.valid);
    end
    look(32'h80000070);
    checks++;
    if (p0 !== {1'b1, 32'h80000170}) begin
      failures++; $display("FAIL rr_wrap_keep: got %h expected %h", p0, {1'b1, 32'h80000170});
    end
  endtask

  task automatic test_inplace();
    clear();
    upd(32'h80000010, 32'h80000100);
    upd(32'h80000030, 32'h80000130);
    upd(32'h80000010, 32'h80000200);
    look(32'h80000010);
    checks++;
    if (p0 !== {1'b1, 32'h80000200}) begin
      failures++; $display("FAIL inplace_target: got %h expected %h", p0, {1'b1, 32'h80000200});
    end
    look(32'h80000030);
    checks++;
    if (p0 !== {1'b1, 32'h80000130}) begin
      failures++; $display("FAIL inplace_other: got %h expected %h", p0, {1'b1, 32'h80000130});
    end
    upd(32'h80000050, 32'h80000150);
    look(32'h80000010);
    checks++;
    if (p0.valid !== 1'b0) begin
      failures++; $display("FAIL inplace_rr_evict: got valid %b expected 0", p0.valid);
    end
    look(32'h80000030);
    checks++;
    if (p0 !== {1'b1, 32'h80000130}) begin
      failures++; $display("FAIL inplace_rr_keep: got %h expected %h", p0, {1'b1, 32'h80000130});
    end
  endtask

  task automatic test_flush_debug();
    // State here: way0=0x050, way1=0x030, rr=1.
    @(negedge clk_i);
    flush_i = 1'b1;
    btb_update_i = '{valid: 1'b1, pc: 32'h80000090, target_address: 32'h80000190};
    @(negedge clk_i);
    flush_i = 1'b0;
    btb_update_i.valid = 1'b0;
    look(32'h80000030);
    checks++;
    if (p0 !== MISS) begin
      failures++; $display("FAIL flush_030: got %h expected %h", p0, MISS);
    end
    look(32'h80000050);
    checks++;
    if (p0 !== MISS) begin
      failures++; $display("FAIL flush_050: got %h expected %h", p0, MISS);
    end
    look(32'h80000090);
    checks++;
    if (p0 !== MISS) begin
      failures++; $display("FAIL flush_drop_update: got %h expected %h", p0, MISS);
    end
    upd(32'h80000010, 32'h80000110);
    upd(32'h80000030, 32'h80000130);
    upd(32'h80000050, 32'h80000150);
    look(32'h80000010);
    checks++;
    if (p0.valid !== 1'b0) begin
      failures++; $display("FAIL flush_rr_evict: got valid %b expected 0", p0.valid);
    end
    look(32'h80000030);
    checks++;
    if (p0 !== {1'b1, 32'h80000130}) begin
      failures++; $display("FAIL flush_rr_keep: got %h expected %h", p0, {1'b1, 32'h80000130});
    end
    @(negedge clk_i);
    debug_mode_i = 1'b1;
    btb_update_i = '{valid: 1'b1, pc: 32'h80000070, target_address: 32'h80000170};
    inv_valid_i  = 1'b1;
    inv_pc_i     = 32'h80000030;
    @(negedge clk_i);
    btb_update_i.valid = 1'b0;
    inv_valid_i = 1'b0;
    look(32'h80000030);
    checks++;
    if (p0 !== {1'b1, 32'h80000130}) begin
      failures++; $display("FAIL debug_lookup_inv: got %h expected %h", p0, {1'b1, 32'h80000130});
    end
    look(32'h80000070);
    checks++;
    if (p0 !== MISS) begin
      failures++; $display("FAIL debug_update: got %h expected %h", p0, MISS);
    end
    debug_mode_i = 1'b0;
  endtask

  task automatic test_inv();
    clear();
    @(negedge clk_i);
    btb_update_i = '{valid: 1'b1, pc: 32'h80000010, target_address: 32'h80000110};
    inv_valid_i  = 1'b1;
    inv_pc_i     = 32'h80000010;
    @(negedge clk_i);
    btb_update_i.valid = 1'b0;
    inv_valid_i = 1'b0;
    look(32'h80000010);
    checks++;
    if (p0 !== MISS) begin
      failures++; $display("FAIL inv_same_cycle: got %h expected %h", p0, MISS);
    end
    upd(32'h80000010, 32'h80000110);
    upd(32'h80000030, 32'h80000130);
    inv(32'h80000050);
    look(32'h80000010);
    checks++;
    if (p0 !== {1'b1, 32'h80000110}) begin
      failures++; $display("FAIL inv_absent_010: got %h expected %h", p0, {1'b1, 32'h80000110});
    end
    look(32'h80000030);
    checks++;
    if (p0 !== {1'b1, 32'h80000130}) begin
      failures++; $display("FAIL inv_absent_030: got %h expected %h", p0, {1'b1, 32'h80000130});
    end
    upd(32'h80000050, 32'h80000150);
    look(32'h80000010);
    checks++;
    if (p0.valid !== 1'b0) begin
      failures++; $display("FAIL inv_rr_evict: got valid %b expected 0", p0.valid);
    end
    inv(32'h80000030);
    look(32'h80000030);
    checks++;
    if (p0 !== MISS) begin
      failures++; $display("FAIL inv_resident: got %h expected %h", p0, MISS);
    end
    look(32'h80000050);
    checks++;
    if (p0 !== {1'b1, 32'h80000150}) begin
      failures++; $display("FAIL inv_keep_050: got %h expected %h", p0, {1'b1, 32'h80000150});
    end
    // way0=0x050, way1 free: update 0x070 fills way1 while 0x050 is invalidated.
    @(negedge clk_i);
    btb_update_i = '{valid: 1'b1, pc: 32'h80000070, target_address: 32'h80000170};
    inv_valid_i  = 1'b1;
    inv_pc_i     = 32'h80000050;
    @(negedge clk_i);
    btb_update_i.valid = 1'b0;
    inv_valid_i = 1'b0;
    look(32'h80000070);
    checks++;
    if (p0 !== {1'b1, 32'h80000170}) begin
      failures++; $display("FAIL both_update: got %h expected %h", p0, {1'b1, 32'h80000170});
    end
    look(32'h80000050);
    checks++;
    if (p0 !== MISS) begin
      failures++; $display("FAIL both_inv: got %h expected %h", p0, MISS);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_ni       = 1'b0;
    clr_i        = 1'b0;
    flush_i      = 1'b0;
    debug_mode_i = 1'b0;
    vpc_i        = '0;
    btb_update_i = '0;
    inv_valid_i  = 1'b0;
    inv_pc_i     = '0;
    test_reset();
    test_basic();
    test_replace();
    test_inplace();
    test_flush_debug();
    test_inv();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
